// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S source arbiter.
// The optional internal test source is enabled with the I2S_TEST_SRC_EN macro.
package i2s_pkg;

    localparam int PCM_W = 24;

    localparam logic [PCM_W-1:0] TEST_PAT_A = 24'h666AAA;
    localparam logic [PCM_W-1:0] TEST_PAT_B = 24'h555999;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        RUN      = 2'd2,
        FADE_OUT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/i2s_gain_stage.sv
// Two-stage signed sample x unsigned gain multiply, followed by a floor shift by GAIN_W.
// flush drops both pipeline stages and clears the output.
module i2s_gain_stage #(
    parameter int DATA_W = 24,
    parameter int GAIN_W = 8
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [GAIN_W:0]   gain,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    // Gain never exceeds 2**GAIN_W, so DATA_W+GAIN_W signed bits hold every product.
    localparam int PROD_W = DATA_W + GAIN_W;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_valid;
    logic                     unused_prod_low;

    assign sample_ext = {{GAIN_W{sample[DATA_W-1]}}, sample};
    assign gain_ext   = {{(DATA_W-1){1'b0}}, gain};

    always_ff @(posedge clk) begin
        if (flush) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            prod_valid <= in_valid;
            if (in_valid) begin
                prod <= sample_ext * gain_ext;
            end
            out_valid <= prod_valid;
            // Taking the upper DATA_W bits is an arithmetic shift right by GAIN_W (floor).
            if (prod_valid) begin
                out_data <= prod[GAIN_W +: DATA_W];
            end
        end
    end

    assign unused_prod_low = ^prod[GAIN_W-1:0];

endmodule

// File: rtl/i2s_source_arbiter.sv
// Click-free selector of one stereo PCM source feeding the I2S converter FIFO write ports.
// Defining I2S_TEST_SRC_EN adds an always-valid test-pattern source at index NUM_SRC.
module i2s_source_arbiter
    import i2s_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int NUM_SRC   = 2,
    parameter int GAIN_W    = 8,
    parameter int GAIN_STEP = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      audio_en,
    input  logic [1:0]                src_sel,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_l,
    input  logic [NUM_SRC*DATA_W-1:0] src_r,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      fifo_full,
    output logic [DATA_W-1:0]         l_data,
    output logic [DATA_W-1:0]         r_data,
    output logic                      l_data_en,
    output logic                      r_data_en,
    output logic [1:0]                cur_src,
    output logic                      fading,
    output logic [1:0]                fsm_state
);

    localparam logic [GAIN_W:0] UNITY = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] STEP  = (GAIN_W+1)'(GAIN_STEP);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [1:0]        src_next;
    logic [GAIN_W:0]   gain;
    logic [GAIN_W:0]   gain_next;
    logic              flush;
    logic              active;
    logic              accept;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_l;
    logic [DATA_W-1:0] sel_r;
`ifdef I2S_TEST_SRC_EN
    logic              test_phase;
`endif

    assign flush  = rst | ~audio_en;
    assign active = (state != IDLE) & ~flush;
    assign accept = active & sel_valid & ~fifo_full;

    // Indices with no backing source read as never valid, i.e. permanently starved.
    always_comb begin
        sel_valid = 1'b0;
        sel_l     = '0;
        sel_r     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_src == 2'(i)) begin
                sel_valid = src_valid[i];
                sel_l     = src_l[i*DATA_W +: DATA_W];
                sel_r     = src_r[i*DATA_W +: DATA_W];
            end
        end
`ifdef I2S_TEST_SRC_EN
        if (cur_src == 2'(NUM_SRC)) begin
            sel_valid = 1'b1;
            sel_l     = test_phase ? DATA_W'(TEST_PAT_B) : DATA_W'(TEST_PAT_A);
            sel_r     = test_phase ? DATA_W'(TEST_PAT_A) : DATA_W'(TEST_PAT_B);
        end
`endif
    end

    // Unselected sources are sunk so upstream producers never stall.
    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (cur_src == 2'(i)) ? accept : (src_valid[i] & active);
        end
    end

    always_comb begin
        gain_next = gain;
        if (accept) begin
            case (state)
                FADE_IN:  gain_next = (gain >= UNITY - STEP) ? UNITY : gain + STEP;
                FADE_OUT: gain_next = (gain <= STEP) ? '0 : gain - STEP;
                default:  gain_next = gain;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        src_next   = cur_src;
        case (state)
            IDLE: begin
                if (audio_en) state_next = FADE_IN;
            end
            FADE_IN: begin
                if (src_sel != cur_src)      state_next = FADE_OUT;
                else if (gain_next == UNITY) state_next = RUN;
            end
            RUN: begin
                if (src_sel != cur_src) state_next = FADE_OUT;
            end
            FADE_OUT: begin
                // An already-silent (e.g. starved) source switches without waiting for samples.
                if (gain_next == '0) begin
                    state_next = FADE_IN;
                    src_next   = src_sel;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state   <= IDLE;
            gain    <= '0;
            cur_src <= src_sel;
        end else begin
            state   <= state_next;
            gain    <= gain_next;
            cur_src <= src_next;
        end
    end

`ifdef I2S_TEST_SRC_EN
    always_ff @(posedge clk) begin
        if (flush) begin
            test_phase <= 1'b0;
        end else if (accept && cur_src == 2'(NUM_SRC)) begin
            test_phase <= ~test_phase;
        end
    end
`endif

    i2s_gain_stage #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W)
    ) u_gain_l (
        .clk       (clk),
        .flush     (flush),
        .in_valid  (accept),
        .sample    (sel_l),
        .gain      (gain),
        .out_data  (l_data),
        .out_valid (l_data_en)
    );

    i2s_gain_stage #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W)
    ) u_gain_r (
        .clk       (clk),
        .flush     (flush),
        .in_valid  (accept),
        .sample    (sel_r),
        .gain      (gain),
        .out_data  (r_data),
        .out_valid (r_data_en)
    );

    assign fading    = (state == FADE_IN) || (state == FADE_OUT);
    assign fsm_state = state;

endmodule

// File: tb/tb_i2s_source_arbiter.sv
// Directed bench for i2s_source_arbiter: fades, source switching, backpressure, boundaries.
// The test-source step follows the I2S_TEST_SRC_EN macro of the build.
module tb_i2s_source_arbiter;
    import i2s_pkg::*;

    localparam int DATA_W  = 24;
    localparam int NUM_SRC = 2;
    localparam int GAIN_W  = 8;

    logic                      clk;
    logic                      rst;
    logic                      audio_en;
    logic [1:0]                src_sel;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_l;
    logic [NUM_SRC*DATA_W-1:0] src_r;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      fifo_full;
    logic [DATA_W-1:0]         l_data;
    logic [DATA_W-1:0]         r_data;
    logic                      l_data_en;
    logic                      r_data_en;
    logic [1:0]                cur_src;
    logic                      fading;
    logic [1:0]                fsm_state;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];

    i2s_source_arbiter #(
        .DATA_W    (DATA_W),
        .NUM_SRC   (NUM_SRC),
        .GAIN_W    (GAIN_W),
        .GAIN_STEP (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .audio_en  (audio_en),
        .src_sel   (src_sel),
        .src_valid (src_valid),
        .src_l     (src_l),
        .src_r     (src_r),
        .src_ready (src_ready),
        .fifo_full (fifo_full),
        .l_data    (l_data),
        .r_data    (r_data),
        .l_data_en (l_data_en),
        .r_data_en (r_data_en),
        .cur_src   (cur_src),
        .fading    (fading),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sample x scaled by gain g/256 with floor rounding.
    function automatic logic [DATA_W-1:0] scaled(input logic [DATA_W-1:0] x, input int g);
        longint p;
        p = longint'($signed(x)) * longint'(g);
        return DATA_W'(p >>> 8);
    endfunction

    task automatic push_up(input logic [DATA_W-1:0] x, input int k_lo, input int k_hi);
        for (int k = k_lo; k <= k_hi; k++) exp_q.push_back(scaled(x, 4*k));
    endtask

    task automatic push_down(input logic [DATA_W-1:0] x, input int k_hi);
        for (int k = k_hi; k >= 1; k--) exp_q.push_back(scaled(x, 4*k));
    endtask

    task automatic wait_strobe(output logic [DATA_W-1:0] l, output logic [DATA_W-1:0] r,
                               output bit ok);
        ok = 1'b0;
        l  = '0;
        r  = '0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (l_data_en) begin
                ok = 1'b1;
                l  = l_data;
                r  = r_data;
                break;
            end
        end
        if (!ok) check("strobe_timeout", 32'(l_data_en), 32'd1);
    endtask

    task automatic drain(input string tag);
        logic [DATA_W-1:0] l, r, e;
        bit ok;
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_strobe(l, r, ok);
            if (!ok) begin
                exp_q.delete();
                break;
            end
            check($sformatf("%s_l[%0d]", tag, n), 32'(l), 32'(e));
            check($sformatf("%s_r[%0d]", tag, n), 32'(r), 32'(e));
            check($sformatf("%s_ren[%0d]", tag, n), 32'(r_data_en), 32'd1);
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] l, r;
        bit ok;
        int strobes, late, ready_hits;

        rst       = 1'b1;
        audio_en  = 1'b1;
        src_sel   = 2'd0;
        src_valid = 2'b01;
        src_l     = {24'h7FFFFF, 24'h100000};
        src_r     = {24'h7FFFFF, 24'h100000};
        fifo_full = 1'b0;
        repeat (3) tick();

        check("rst_state", 32'(fsm_state), 32'(IDLE));
        check("rst_len", 32'(l_data_en), 32'd0);
        check("rst_ldata", 32'(l_data), 32'd0);
        check("rst_rdata", 32'(r_data), 32'd0);
        check("rst_fading", 32'(fading), 32'd0);
        check("rst_cur_src", 32'(cur_src), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);

        rst = 1'b0;
        #1;
        check("idle_no_accept", 32'(src_ready), 32'd0);

        // 1: fade-in of src0 from gain 0 to unity
        push_up(24'h100000, 0, 64);
        drain("t1_ramp");
        check("t1_state_run", 32'(fsm_state), 32'(RUN));
        check("t1_fading", 32'(fading), 32'd0);

        // 2: RUN switch to src1; two RUN samples in flight, then fade-out, then fade-in
        src_valid = 2'b11;
        src_sel   = 2'd1;
        exp_q.push_back(24'h100000);
        exp_q.push_back(24'h100000);
        push_down(24'h100000, 64);
        drain("t2_out");
        check("t2_cur_src", 32'(cur_src), 32'd1);
        check("t2_fading", 32'(fading), 32'd1);
        check("t2_ready_sink", 32'(src_ready), 32'h3);
        push_up(24'h7FFFFF, 0, 64);
        drain("t2_in");
        check("t2_state_run", 32'(fsm_state), 32'(RUN));

        // 3: back to src0, then retarget mid fade-in at gain 128 in both directions
        src_sel = 2'd0;
        exp_q.push_back(24'h7FFFFF);
        exp_q.push_back(24'h7FFFFF);
        push_down(24'h7FFFFF, 64);
        push_up(24'h100000, 0, 29);
        drain("t3_a");
        src_sel = 2'd1;
        push_up(24'h100000, 30, 31);
        push_down(24'h100000, 32);
        drain("t3_b");
        check("t3_cur_src1", 32'(cur_src), 32'd1);
        push_up(24'h7FFFFF, 0, 29);
        drain("t3_c");
        src_sel = 2'd0;
        check("t3_retarget_fading", 32'(fading), 32'd1);
        push_up(24'h7FFFFF, 30, 31);
        push_down(24'h7FFFFF, 32);
        drain("t3_d");
        check("t3_cur_src0", 32'(cur_src), 32'd0);
        push_up(24'h100000, 0, 64);
        drain("t3_e");
        check("t3_state_run", 32'(fsm_state), 32'(RUN));

        // 4: backpressure for 50 cycles
        fifo_full = 1'b1;
        #1;
        check("t4_ready_blocked", 32'(src_ready[0]), 32'd0);
        strobes    = 0;
        late       = 0;
        ready_hits = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (l_data_en) begin
                strobes++;
                if (i >= 2) late++;
            end
            if (src_ready[0]) ready_hits++;
        end
        check("t4_ready_count", 32'(ready_hits), 32'd0);
        check("t4_late_strobes", 32'(late), 32'd0);
        check("t4_strobes_le2", 32'(strobes <= 2), 32'd1);
        fifo_full = 1'b0;
        #1;
        check("t4_release_ready", 32'(src_ready[0]), 32'd1);
        tick();
        check("t4_gap", 32'(l_data_en), 32'd0);
        tick();
        check("t4_resume_en", 32'(l_data_en), 32'd1);
        check("t4_resume_data", 32'(l_data), 32'h100000);
        tick();
        check("t4_rate_en", 32'(l_data_en), 32'd1);

        // 5: negative full scale on src1
        src_l[DATA_W +: DATA_W] = 24'h800000;
        src_r[DATA_W +: DATA_W] = 24'h800000;
        src_sel = 2'd1;
        exp_q.push_back(24'h100000);
        exp_q.push_back(24'h100000);
        push_down(24'h100000, 64);
        push_up(24'h800000, 0, 31);
        drain("t5_a");
        wait_strobe(l, r, ok);
        check("t5_half_l", 32'(l), 32'hC00000);
        check("t5_half_r", 32'(r), 32'hC00000);
        push_up(24'h800000, 33, 63);
        drain("t5_b");
        wait_strobe(l, r, ok);
        check("t5_unity_l", 32'(l), 32'h800000);
        check("t5_unity_r", 32'(r), 32'h800000);

        // 6: index NUM_SRC
        src_sel = 2'd2;
        exp_q.push_back(24'h800000);
        exp_q.push_back(24'h800000);
        push_down(24'h800000, 64);
        drain("t6_out");
`ifdef I2S_TEST_SRC_EN
        for (int i = 0; i < 65; i++) wait_strobe(l, r, ok);
        wait_strobe(l, r, ok);
        begin
            logic [DATA_W-1:0] l2, r2;
            wait_strobe(l2, r2, ok);
            check("t6_ts_pair",
                  32'((l == 24'h666AAA && l2 == 24'h555999) || (l == 24'h555999 && l2 == 24'h666AAA)),
                  32'd1);
            check("t6_ts_r", 32'(r), 32'(l == 24'h666AAA ? 24'h555999 : 24'h666AAA));
        end
`else
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (l_data_en) strobes++;
        end
        check("t6_no_strobes", 32'(strobes), 32'd0);
        check("t6_state", 32'(fsm_state), 32'(FADE_IN));
        check("t6_cur_src", 32'(cur_src), 32'd2);
        check("t6_fading", 32'(fading), 32'd1);
        check("t6_ready_sink", 32'(src_ready), 32'h3);
        src_sel = 2'd0;
        push_up(24'h100000, 0, 3);
        drain("t6_frozen");
`endif

        // audio_en drop mid-stream: flush, cur_src follows src_sel
        audio_en = 1'b0;
        src_sel  = 2'd1;
        tick();
        check("en_drop_len", 32'(l_data_en), 32'd0);
        check("en_drop_ren", 32'(r_data_en), 32'd0);
        check("en_drop_ldata", 32'(l_data), 32'd0);
        check("en_drop_state", 32'(fsm_state), 32'(IDLE));
        check("en_drop_cur_src", 32'(cur_src), 32'd1);
        check("en_drop_ready", 32'(src_ready), 32'd0);
        tick();
        check("en_drop_len2", 32'(l_data_en), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
